alu_seq: RTL



---
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with serial shifts and an optional iterative shift-add multiplier.
// The operation encoding package lives here so the design stays a single self-contained file.
package alu_types_pkg;
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_control_t;
endpackage

module alu_seq
    import alu_types_pkg::*;
#(
    parameter int N      = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    input  logic         op_mul,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    localparam int SW = $clog2(N);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    alu_control_t   ctl_r;
    logic           mul_r;
    logic [2*N-1:0] work_r;
    logic [CW-1:0]  count_r;

    logic [N-1:0]   sum_s;
    logic [N-1:0]   diff_s;
    logic [N-1:0]   shifted_s;
    logic [N:0]     mul_sum_s;
    logic [2*N-1:0] mul_next_s;
    logic [2*N-1:0] work_next_s;
    logic [N-1:0]   fin_res_s;
    logic           fin_ovf_s;
    logic           fin_legal_s;
    logic           fin_last_s;

    function automatic logic [N-1:0] shift_step(input alu_control_t op, input logic [N-1:0] v);
        logic [N-1:0] r;
        case (op)
            ALU_SLL: r = {v[N-2:0], 1'b0};
            ALU_SRL: r = {1'b0, v[N-1:1]};
            ALU_SRA: r = {v[N-1], v[N-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Per-BUSY-cycle datapath: next working value, and the result if this cycle completes
    always_comb begin
        sum_s       = a_r + b_r;
        diff_s      = a_r - b_r;
        shifted_s   = shift_step(ctl_r, work_r[N-1:0]);
        // work_r holds {partial product, remaining multiplier bits} during MUL
        mul_sum_s   = {1'b0, work_r[2*N-1:N]} + (work_r[0] ? {1'b0, a_r} : {(N+1){1'b0}});
        mul_next_s  = {mul_sum_s, work_r[N-1:1]};
        work_next_s = work_r;
        fin_res_s   = {N{1'b0}};
        fin_ovf_s   = 1'b0;
        fin_legal_s = 1'b1;
        fin_last_s  = 1'b1;
        if (mul_r) begin
            if (MUL_EN) begin
                work_next_s = mul_next_s;
                fin_last_s  = (count_r == CW'(1));
                fin_res_s   = mul_next_s[N-1:0];
                fin_ovf_s   = |mul_next_s[2*N-1:N];
            end else begin
                fin_last_s  = 1'b1;
            end
        end else begin
            case (ctl_r)
                ALU_AND:  fin_res_s = a_r & b_r;
                ALU_OR:   fin_res_s = a_r | b_r;
                ALU_XOR:  fin_res_s = a_r ^ b_r;
                ALU_ADD: begin
                    fin_res_s = sum_s;
                    fin_ovf_s = (a_r[N-1] == b_r[N-1]) && (sum_s[N-1] != a_r[N-1]);
                end
                ALU_SUB: begin
                    fin_res_s = diff_s;
                    fin_ovf_s = (a_r[N-1] != b_r[N-1]) && (diff_s[N-1] != a_r[N-1]);
                end
                ALU_SLT:  fin_res_s = {{(N-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
                ALU_SLTU: fin_res_s = {{(N-1){1'b0}}, (a_r < b_r)};
                ALU_SLL, ALU_SRL, ALU_SRA: begin
                    work_next_s = {{N{1'b0}}, shifted_s};
                    fin_last_s  = (count_r < CW'(2));
                    fin_res_s   = (count_r == CW'(0)) ? work_r[N-1:0] : shifted_s;
                end
                default:  fin_legal_s = 1'b0;
            endcase
        end
    end

    // Control FSM with capture registers and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_r       <= {N{1'b0}};
            b_r       <= {N{1'b0}};
            ctl_r     <= ALU_AND;
            mul_r     <= 1'b0;
            work_r    <= {(2*N){1'b0}};
            count_r   <= {CW{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= {N{1'b0}};
            overflow  <= 1'b0;
            zero      <= 1'b0;
            equal     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        ctl_r    <= control;
                        mul_r    <= op_mul;
                        work_r   <= op_mul ? {{N{1'b0}}, b} : {{N{1'b0}}, a};
                        count_r  <= op_mul ? CW'(N) : {1'b0, b[SW-1:0]};
                        in_ready <= 1'b0;
                        state_r  <= BUSY;
                    end
                end
                BUSY: begin
                    if (fin_last_s) begin
                        result    <= fin_res_s;
                        overflow  <= fin_legal_s & fin_ovf_s;
                        zero      <= fin_legal_s & (fin_res_s == {N{1'b0}});
                        equal     <= fin_legal_s & (a_r == b_r);
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        work_r  <= work_next_s;
                        count_r <= count_r - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        result    <= {N{1'b0}};
                        overflow  <= 1'b0;
                        zero      <= 1'b0;
                        equal     <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
